// File: rtl/relu_backward.sv
// ReLU backward stage: captures a strictly-positive mask from the forward vector and gates a
// gradient stream with it. Define RELU_BWD_LEAKY_EN to pass masked elements as grad >>> LEAK_SHIFT.
module relu_backward #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mask_load,
    input  logic [WIDTH*DEPTH-1:0] fwd_data,
    output logic                   mask_valid,
    input  logic                   grad_valid,
    output logic                   grad_ready,
    input  logic [WIDTH-1:0]       grad_data,
    input  logic                   grad_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic                   err_len
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

    if (LEAK_SHIFT >= WIDTH) begin : g_leak_shift_check
        $error("LEAK_SHIFT must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {StEmpty, StArmed, StStream} state_e;

    state_e           state;
    logic [DEPTH-1:0] mask;
    logic [DEPTH-1:0] mask_next;
    logic [IW-1:0]    index;
    logic             slot_free;
    logic             accept;
    logic             capture;
    logic             at_last_idx;
    logic             end_vec;
    logic             len_err;
    logic [WIDTH-1:0] masked_val;

    // Derivative is 1 only for strictly positive elements (sign clear and nonzero).
    always_comb begin
        mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mask_next[i] = !fwd_data[WIDTH*i + WIDTH - 1] && (|fwd_data[WIDTH*i +: WIDTH]);
        end
    end

`ifdef RELU_BWD_LEAKY_EN
    assign masked_val = $signed(grad_data) >>> LEAK_SHIFT;
`else
    assign masked_val = '0;
`endif

    assign slot_free   = !out_valid || out_ready;
    assign mask_valid  = (state != StEmpty);
    assign capture     = mask_load && (state != StStream);
    assign accept      = grad_valid && grad_ready;
    assign at_last_idx = (index == LastIdx);
    assign end_vec     = grad_last || at_last_idx;
    // Early end and missing last are exactly the cases where the two end markers disagree.
    assign len_err     = grad_last ^ at_last_idx;

    // A mask capture outside STREAM takes priority over an incoming gradient word.
    always_comb begin
        grad_ready = 1'b0;
        unique case (state)
            StArmed:  grad_ready = slot_free && !mask_load;
            StStream: grad_ready = slot_free;
            default:  grad_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StEmpty;
            mask      <= '0;
            index     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            if (capture) begin
                mask    <= mask_next;
                state   <= StArmed;
                err_len <= 1'b0;
            end
            if (accept) begin
                out_data  <= mask[index] ? grad_data : masked_val;
                out_valid <= 1'b1;
                out_last  <= end_vec;
                if (len_err) begin
                    err_len <= 1'b1;
                end
                if (end_vec) begin
                    index <= '0;
                    state <= StArmed;
                end else begin
                    index <= index + 1'b1;
                    state <= StStream;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward: queue-based reference model checked every cycle,
// plus hand-computed literals for the directed scenarios.
module tb_relu_backward;

    localparam int W = 32;
    localparam int D = 64;
`ifdef RELU_BWD_LEAKY_EN
    localparam bit Leaky = 1'b1;
`else
    localparam bit Leaky = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mask_load = 1'b0;
    logic [W*D-1:0] fwd_data = '0;
    logic         grad_valid = 1'b0;
    logic [W-1:0] grad_data = '0;
    logic         grad_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         mask_valid;
    logic         grad_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         err_len;

    relu_backward #(
        .WIDTH      (W),
        .DEPTH      (D),
        .LEAK_SHIFT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mask_load  (mask_load),
        .fwd_data   (fwd_data),
        .mask_valid (mask_valid),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_data  (grad_data),
        .grad_last  (grad_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mask bits, held flag, element index, sticky error, output slot queue.
    typedef struct {
        logic [31:0] d;
        logic        l;
    } ow_t;

    bit [D-1:0]  m_mask;
    bit          m_held;
    int          m_idx;
    bit          m_err;
    ow_t         q[$];
    logic [31:0] log_d[256];
    logic        log_l[256];
    int          log_c[256];
    int          logn;
    int          acc0_cyc;

    always @(negedge clk) begin
        bit               streaming;
        bit               exp_ready;
        logic signed [31:0] g;
        logic signed [31:0] e;
        ow_t              w;
        if (rst) begin
            q.delete();
            m_held = 1'b0;
            m_idx  = 0;
            m_err  = 1'b0;
            m_mask = '0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_grad_ready", grad_ready, 0);
            chk("rst_mask_valid", mask_valid, 0);
            chk("rst_err_len", err_len, 0);
        end else begin
            streaming = (m_idx != 0);
            exp_ready = m_held && !(mask_load && !streaming) && (q.size() == 0 || out_ready);
            chk("grad_ready", grad_ready, exp_ready);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].d);
                chk("out_last", out_last, q[0].l);
            end
            chk("mask_valid", mask_valid, m_held);
            chk("err_len", err_len, m_err);
            if (out_valid && out_ready && q.size() != 0) begin
                if (logn < 256) begin
                    log_d[logn] = out_data;
                    log_l[logn] = out_last;
                    log_c[logn] = cyc;
                    logn++;
                end
                void'(q.pop_front());
            end
            if (grad_valid && exp_ready) begin
                g = grad_data;
                if (m_mask[m_idx]) w.d = g;
                else w.d = Leaky ? (g >>> 3) : 32'sd0;
                w.l = grad_last || (m_idx == D - 1);
                if ((grad_last && m_idx < D - 1) || (m_idx == D - 1 && !grad_last)) m_err = 1'b1;
                if (m_idx == 0) acc0_cyc = cyc;
                m_idx = w.l ? 0 : m_idx + 1;
                q.push_back(w);
            end
            if (mask_load && !streaming) begin
                for (int i = 0; i < D; i++) begin
                    e = fwd_data[W*i +: W];
                    m_mask[i] = (e > 0);
                end
                m_held = 1'b1;
                m_err  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mask();
        mask_load = 1'b1;
        tick();
        mask_load = 1'b0;
    endtask

    // Holds grad_valid high until the word is taken; bounded so a stuck DUT cannot hang the run.
    task automatic send(input logic [31:0] d, input logic l);
        bit acc;
        grad_valid = 1'b1;
        grad_data  = d;
        grad_last  = l;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = grad_ready;
            @(posedge clk);
            #1;
        end
        nvec++;
        if (!acc) begin
            nerr++;
            $display("FAIL send_timeout: got no accept, expected accept of %0h", d);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] lk100;
    logic [31:0] a_d[D];
    logic [31:0] v;

    initial begin
        lk100 = Leaky ? 32'd12 : 32'd0;
        repeat (2) tick();
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_mask_valid", mask_valid, 0);
        rst = 1'b0;
        tick();

        // Mask rule and full-throughput vector
        for (int i = 0; i < D; i++) begin
            if (i % 7 == 0) v = 32'd0;
            else if (i % 3 == 0) v = -i;
            else v = i * 1000;
            fwd_data[W*i +: W] = v;
        end
        fwd_data[W*0 +: W] = 32'd5;
        fwd_data[W*1 +: W] = -32'd3;
        fwd_data[W*2 +: W] = 32'd0;
        fwd_data[W*3 +: W] = 32'h7FFF_FFFF;
        fwd_data[W*4 +: W] = 32'h8000_0000;
        load_mask();
        out_ready = 1'b1;
        logn = 0;
        for (int i = 0; i < D; i++) send(32'd100, i == D - 1);
        grad_valid = 1'b0;
        repeat (3) tick();
        chk("tp_count", logn, 64);
        chk("mask_e0", log_d[0], 100);
        chk("mask_e1", log_d[1], lk100);
        chk("mask_e2", log_d[2], lk100);
        chk("mask_e3", log_d[3], 100);
        chk("mask_e4", log_d[4], lk100);
        chk("tp_last62", log_l[62], 0);
        chk("tp_last63", log_l[63], 1);
        chk("tp_latency", log_c[0] - acc0_cyc, 1);
        chk("tp_span", log_c[63] - log_c[0], 63);
        chk("tp_err_len", err_len, 0);

        // Backpressure mid-vector
        logn = 0;
        fork
            for (int i = 0; i < D; i++) send(32'(i * 7 - 50), i == D - 1);
            begin
                repeat (20) tick();
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
            end
        join
        grad_valid = 1'b0;
        repeat (3) tick();
        chk("bp_count", logn, 64);
        chk("bp_e0", log_d[0], 32'hFFFF_FFCE);
        chk("bp_e1", log_d[1], Leaky ? 32'hFFFF_FFFA : 32'd0);
        chk("bp_last", log_l[63], 1);

        // Early end on word 10, then a missing-last vector
        logn = 0;
        for (int i = 0; i <= 10; i++) send(32'(i + 1), i == 10);
        grad_valid = 1'b0;
        repeat (2) tick();
        chk("early_count", logn, 11);
        chk("early_last", log_l[10], 1);
        chk("early_err", err_len, 1);
        logn = 0;
        for (int i = 0; i < D; i++) send(32'd200, 1'b0);
        grad_valid = 1'b0;
        repeat (2) tick();
        chk("miss_restart", log_d[0], 200);
        chk("miss_e1", log_d[1], Leaky ? 32'd25 : 32'd0);
        chk("miss_last", log_l[63], 1);
        chk("miss_err", err_len, 1);

        // mask_load coincident with a gradient word wins and clears err_len
        grad_valid = 1'b1;
        grad_data  = 32'd7;
        grad_last  = 1'b0;
        mask_load  = 1'b1;
        tick();
        mask_load = 1'b0;
        chk("reload_err_clear", err_len, 0);
        for (int i = 0; i < D; i++) send(32'd7, i == D - 1);
        grad_valid = 1'b0;
        repeat (2) tick();
        chk("reload_err_stays", err_len, 0);

        // mask_load during STREAM is ignored; mask reused across two vectors
        logn = 0;
        fork
            for (int i = 0; i < D; i++) send(32'(1000 + i), i == D - 1);
            begin
                repeat (5) tick();
                for (int i = 0; i < D; i++) fwd_data[W*i +: W] = 32'd1;
                mask_load = 1'b1;
                tick();
                mask_load = 1'b0;
            end
        join
        grad_valid = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < D; i++) a_d[i] = log_d[i];
        chk("ignore_e1", a_d[1], Leaky ? 32'd125 : 32'd0);
        logn = 0;
        for (int i = 0; i < D; i++) send(32'(1000 + i), i == D - 1);
        grad_valid = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < D; i++) chk("mask_reuse", log_d[i], a_d[i]);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 20; i++) send(32'(i), 1'b0);
        grad_data = 32'd20;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_mask_valid", mask_valid, 0);
        chk("arst_grad_ready", grad_ready, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_ready", grad_ready, 0);
        grad_valid = 1'b0;
        load_mask();
        logn = 0;
        send(32'd55, 1'b1);
        grad_valid = 1'b0;
        repeat (3) tick();
        chk("post_rst_data", log_d[0], 55);
        chk("post_rst_err", err_len, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
